hazard_scoreboard: RTL and testbench
====================================

// Module: hazard_scoreboard
// PURPOSE
//  Parametrised hazard/forwarding controller for the 5-stage MIPS pipeline (F/D/E/M/W).
//  Unlike a purely combinational unit, it keeps its own shadow of the destinations in E/M/W
//  and an internal mult/div busy countdown with per-op latency, so the datapath only reports
//  decode-stage info. Also provides a saturating stall-cycle performance counter.
//  Sits beside the controller; drives stall/flush and forwarding-mux selects.
// PARAMETERS
//  RW        5    register-index width
//  MULT_LAT  5    cycles HI/LO busy after mult/multu accepted in D
//  DIV_LAT   10   cycles HI/LO busy after div/divu accepted in D
//  CNT_W     32   stall performance counter width
// PORTS
//  clk          in   1    clock, rising edge
//  reset        in   1    asynchronous, active-high
//  rs_d, rt_d   in   RW   D-stage source registers
//  use_rs_d     in   1    D instr reads rs;  use_rt_d in 1: D instr reads rt
//  early_d      in   1    D instr consumes sources in D (beq/bne/bgtz/blez/bltz/bgez/jr/jalr)
//  dst_d        in   RW   D-stage destination; wr_d in 1: D instr writes GPR
//  load_d       in   1    D instr is a load (result valid at end of M)
//  md_start_d   in   1    D instr is mult/div; md_div_d in 1: 1=div, 0=mult
//  md_acc_d     in   1    D instr is mfhi/mflo/mthi/mtlo
//  ext_stall    in   1    memory wait: freeze whole pipeline
//  flush_req    in   1    exception/eret: discard D instr this cycle
//  rs_e, rt_e   in   RW   E-stage sources (for E forwarding)
//  stall_f, stall_d  out 1  hold PC / IF-ID
//  flush_e      out  1    insert bubble into ID-EX
//  fwd_a_d, fwd_b_d  out 1  D compare operand from M result
//  fwd_a_e, fwd_b_e  out 2  E ALU operand: 00 regfile, 01 W, 10 M
//  md_busy      out  1    HI/LO countdown nonzero
//  stall_cnt    out  CNT_W  cycles with hazard stall asserted, saturating
// BEHAVIOUR
//  Reset: shadow E/M/W entries invalid, countdown 0, stall_cnt 0; all outputs 0.
//  Shadow entry = {valid, dst, load}; valid only if wr && dst!=0.
//  Each cycle (ext_stall=0): W<=M, M<=E, E<=(hz|flush_req)?invalid:D-info. ext_stall=1: hold.
//  Match(x,S) = S.valid && S.dst==x && use of x in D.
//  Hazard stall hz (combinational, registered nowhere):
//   - load-use: Match(rs_d|rt_d, E) && E.load
//   - early-use: early_d && (Match(.,E) || (Match(.,M) && M.load))
//   - md: (md_busy || countdown reload this cycle impossible) && (md_start_d || md_acc_d)
//  stall_f=stall_d=hz|ext_stall; flush_e=(hz|flush_req)&~ext_stall.
//  Forwarding (combinational): M priority over W; rsrc 0 never forwarded.
//   fwd_a_e=10 if M.valid&&M.dst==rs_e&&!M.load ... load in M never forwarded to E (hz
//   guarantees load is in W by then -> 01). fwd_*_d=1 if M.valid&&!M.load&&M.dst==src.
//  Countdown: md_start_d accepted (hz=0, flush_req=0, ext_stall=0) loads MULT_LAT or DIV_LAT
//   on next edge; else decrements to 0 every cycle, including during ext_stall.
//  md_busy = countdown!=0; start accepted when countdown==1 next cycle... not possible:
//   md rule blocks while md_busy, so first issue is the cycle countdown reaches 0.
//  stall_cnt increments on edges where hz=1; holds at all-ones; ext_stall cycles not counted.
//  flush_req && hz same cycle: flush_e=1, D instr discarded, stall_f/stall_d still 1.
//  reset mid-countdown: countdown and shadow cleared immediately (async).
// STRUCTURE
//  Shared package/header: forwarding-select encodings (FWD_RF/FWD_W/FWD_M), shadow-entry
//  field widths, default MULT_LAT/DIV_LAT.
//  One sub-module: md_busy_timer (load value, decrement, busy flag); rest is flat.
// TESTING
//  lw $8 in E, add $9,$8,$1 in D -> hz=1 one cycle, flush_e=1, then fwd_a_e=01 (from W).
//  add $3 in M, beq $3,$4 in D -> no stall, fwd_a_d=1; same with add in E -> 1 stall cycle.
//  lw $5 in M, jr $5 in D -> 1 stall; next cycle lw in W, jr proceeds, fwd_a_d=0.
//  div accepted, mfhi next -> md_busy for 10 cycles, stall_cnt +10, mfhi issues cycle 11;
//   repeat with MULT_LAT=5 and mult -> 5 stall cycles.
//  writes to $0 in E/M/W with rs_e=0 -> fwd_a_e=00, no stall.
//  ext_stall=1 for 3 cycles during load-use -> shadow held, stall_cnt unchanged; reset
//   asserted mid-div -> md_busy=0, stall_cnt=0 same cycle; CNT_W=4 saturates at 15.

Source files
------------

// File: rtl/hazard_scoreboard_pkg.sv
// Shared encodings and defaults for the hazard/forwarding scoreboard of the 5-stage pipeline.
package hazard_scoreboard_pkg;

   // Forwarding-mux selects for the E-stage ALU operands
   localparam logic [1:0] FWD_RF = 2'b00;
   localparam logic [1:0] FWD_W  = 2'b01;
   localparam logic [1:0] FWD_M  = 2'b10;

   // Shadow-entry field widths: {valid, dst[RW-1:0], load}
   localparam int SH_VALID_W = 1;
   localparam int SH_LOAD_W  = 1;

   localparam int DEF_RW       = 5;
   localparam int DEF_MULT_LAT = 5;
   localparam int DEF_DIV_LAT  = 10;
   localparam int DEF_CNT_W    = 32;

   function automatic int latWidth(input int lat);
      return $clog2(lat + 1);
   endfunction

endpackage

// File: rtl/hazard_scoreboard_if.sv
// Decode/execute-stage signals exchanged between the datapath (master) and the scoreboard (slave).
interface hazard_scoreboard_if import hazard_scoreboard_pkg::*; #(
   parameter int RW    = DEF_RW,
   parameter int CNT_W = DEF_CNT_W
) ();

   logic [RW-1:0]    rs_d, rt_d, dst_d;
   logic             use_rs_d, use_rt_d, early_d, wr_d, load_d;
   logic             md_start_d, md_div_d, md_acc_d;
   logic             ext_stall, flush_req;
   logic [RW-1:0]    rs_e, rt_e;
   logic             stall_f, stall_d, flush_e;
   logic             fwd_a_d, fwd_b_d;
   logic [1:0]       fwd_a_e, fwd_b_e;
   logic             md_busy;
   logic [CNT_W-1:0] stall_cnt;

   // The D instruction is taken into E on a rising edge when stall_d=0 and flush_req=0;
   // ext_stall=1 freezes every stage, so nothing moves on that edge.
   modport master (
      output rs_d, rt_d, dst_d, use_rs_d, use_rt_d, early_d, wr_d, load_d,
      output md_start_d, md_div_d, md_acc_d, ext_stall, flush_req, rs_e, rt_e,
      input  stall_f, stall_d, flush_e, fwd_a_d, fwd_b_d, fwd_a_e, fwd_b_e,
      input  md_busy, stall_cnt
   );

   modport slave (
      input  rs_d, rt_d, dst_d, use_rs_d, use_rt_d, early_d, wr_d, load_d,
      input  md_start_d, md_div_d, md_acc_d, ext_stall, flush_req, rs_e, rt_e,
      output stall_f, stall_d, flush_e, fwd_a_d, fwd_b_d, fwd_a_e, fwd_b_e,
      output md_busy, stall_cnt
   );

endinterface

// File: rtl/hazard_scoreboard_md_busy_timer.sv
// HI/LO busy countdown: reloads with the mult or div latency on an accepted start, else runs down to 0.
module md_busy_timer import hazard_scoreboard_pkg::*; #(
   parameter int MULT_LAT = DEF_MULT_LAT,
   parameter int DIV_LAT  = DEF_DIV_LAT
) (
   input  logic clk,
   input  logic reset,
   input  logic start,
   input  logic isDiv,
   output logic busy
);

   localparam int MAX_LAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
   localparam int CW      = latWidth(MAX_LAT);

   logic [CW-1:0] count;

   // Keeps counting through ext_stall: the multiplier runs regardless of the memory wait.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         count <= '0;
      else if (start)
         count <= isDiv ? CW'(DIV_LAT) : CW'(MULT_LAT);
      else if (count != '0)
         count <= count - CW'(1);
   end

   assign busy = (count != '0);

endmodule

// File: rtl/hazard_scoreboard.sv
// Hazard/forwarding controller keeping its own E/M/W destination shadow, HI/LO busy timer and stall counter.
module hazard_scoreboard import hazard_scoreboard_pkg::*; #(
   parameter int RW       = DEF_RW,
   parameter int MULT_LAT = DEF_MULT_LAT,
   parameter int DIV_LAT  = DEF_DIV_LAT,
   parameter int CNT_W    = DEF_CNT_W
) (
   input logic              clk,
   input logic              reset,
   hazard_scoreboard_if.slave sb
);

   typedef struct packed {
      logic [SH_VALID_W-1:0] valid;
      logic [RW-1:0]         dst;
      logic [SH_LOAD_W-1:0]  load;
   } shadow_t;

   shadow_t          shE, shM, shW, shD;
   logic             hitE, hitM, loadUse, earlyUse, mdHaz, hz;
   logic             mdBusy, mdStart;
   logic [CNT_W-1:0] stallCnt;

   function automatic logic hit(input shadow_t s, input logic [RW-1:0] src, input logic rd);
      return rd && (s.valid != '0) && (s.dst == src);
   endfunction

   // M wins over W; a load sitting in M never feeds E (the load-use stall pushes it to W first).
   function automatic logic [1:0] fwdE(input shadow_t m, input shadow_t w, input logic [RW-1:0] src);
      if ((m.valid != '0) && (m.load == '0) && (m.dst == src)) return FWD_M;
      if ((w.valid != '0) && (w.dst == src))                   return FWD_W;
      return FWD_RF;
   endfunction

   always_comb begin
      shD       = '0;
      shD.valid = SH_VALID_W'(sb.wr_d && (sb.dst_d != '0));
      shD.dst   = sb.dst_d;
      shD.load  = SH_LOAD_W'(sb.load_d);
      hitE      = hit(shE, sb.rs_d, sb.use_rs_d) || hit(shE, sb.rt_d, sb.use_rt_d);
      hitM      = hit(shM, sb.rs_d, sb.use_rs_d) || hit(shM, sb.rt_d, sb.use_rt_d);
      loadUse   = hitE && (shE.load != '0);
      earlyUse  = sb.early_d && (hitE || (hitM && (shM.load != '0)));
      mdHaz     = mdBusy && (sb.md_start_d || sb.md_acc_d);
      hz        = loadUse || earlyUse || mdHaz;
      mdStart   = sb.md_start_d && !hz && !sb.flush_req && !sb.ext_stall;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         shE <= '0;
         shM <= '0;
         shW <= '0;
      end else if (!sb.ext_stall) begin
         shW <= shM;
         shM <= shE;
         shE <= (hz || sb.flush_req) ? '0 : shD;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         stallCnt <= '0;
      else if (hz && !sb.ext_stall && (stallCnt != '1))
         stallCnt <= stallCnt + CNT_W'(1);
   end

   md_busy_timer #(
      .MULT_LAT(MULT_LAT),
      .DIV_LAT (DIV_LAT)
   ) uTimer (
      .clk  (clk),
      .reset(reset),
      .start(mdStart),
      .isDiv(sb.md_div_d),
      .busy (mdBusy)
   );

   assign sb.stall_f   = hz || sb.ext_stall;
   assign sb.stall_d   = hz || sb.ext_stall;
   assign sb.flush_e   = (hz || sb.flush_req) && !sb.ext_stall;
   assign sb.fwd_a_d   = (shM.valid != '0) && (shM.load == '0) && (shM.dst == sb.rs_d);
   assign sb.fwd_b_d   = (shM.valid != '0) && (shM.load == '0) && (shM.dst == sb.rt_d);
   assign sb.fwd_a_e   = fwdE(shM, shW, sb.rs_e);
   assign sb.fwd_b_e   = fwdE(shM, shW, sb.rt_e);
   assign sb.md_busy   = mdBusy;
   assign sb.stall_cnt = stallCnt;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed pipeline scenarios for hazard_scoreboard; expected output vectors queued per cycle.
module tb_hazard_scoreboard;

   logic clk;
   logic reset;
   int   total = 0;
   int   bad   = 0;

   logic [13:0] exp_q[$];
   string       tag_q[$];

   hazard_scoreboard_if #(.RW(5), .CNT_W(4)) sb ();

   hazard_scoreboard #(
      .RW      (5),
      .MULT_LAT(5),
      .DIV_LAT (10),
      .CNT_W   (4)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .sb   (sb)
   );

   // clock / watchdog
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached, got=running required=finished");
      $fatal(1, "watchdog");
   end

   // driver tasks
   task automatic setD(input logic [4:0] rs, input logic [4:0] rt, input logic urs, input logic urt,
                       input logic early, input logic [4:0] dst, input logic wr, input logic ld);
      sb.rs_d = rs;  sb.rt_d = rt;  sb.use_rs_d = urs;  sb.use_rt_d = urt;
      sb.early_d = early;  sb.dst_d = dst;  sb.wr_d = wr;  sb.load_d = ld;
      sb.md_start_d = 1'b0;  sb.md_div_d = 1'b0;  sb.md_acc_d = 1'b0;
   endtask

   task automatic idleD();
      setD(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
   endtask

   task automatic setE(input logic [4:0] rs, input logic [4:0] rt);
      sb.rs_e = rs;
      sb.rt_e = rt;
   endtask

   // {stall_f, stall_d, flush_e, fwd_a_d, fwd_b_d, fwd_a_e, fwd_b_e, md_busy, stall_cnt}
   function automatic logic [13:0] ev(input logic stl, input logic fe, input logic fad, input logic fbd,
                                      input logic [1:0] fae, input logic [1:0] fbe,
                                      input logic busy, input int cnt);
      logic [3:0] c;
      c = cnt[3:0];
      return {stl, stl, fe, fad, fbd, fae, fbe, busy, c};
   endfunction

   // scoreboard check
   task automatic checkEq(input string tag, input logic [13:0] got, input logic [13:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s: got=%b required=%b (sf sd fe fad fbd fae fbe busy cnt)", tag, got, want);
      end
   endtask

   // Queue the expectation for the current input set, compare on the falling edge, advance a cycle.
   task automatic step(input string tag, input logic [13:0] want);
      logic [13:0] obs;
      exp_q.push_back(want);
      tag_q.push_back(tag);
      @(negedge clk);
      obs = {sb.stall_f, sb.stall_d, sb.flush_e, sb.fwd_a_d, sb.fwd_b_d,
             sb.fwd_a_e, sb.fwd_b_e, sb.md_busy, sb.stall_cnt};
      checkEq(tag_q.pop_front(), obs, exp_q.pop_front());
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset = 1'b1;
      idleD();
      setE(5'd0, 5'd0);
      sb.ext_stall = 1'b0;
      sb.flush_req = 1'b0;
      @(posedge clk);
      #1;
      step("reset", ev(0, 0, 0, 0, 2'b00, 2'b00, 0, 0));
      reset = 1'b0;

      // lw $8 then dependent add: one load-use bubble, then operand from W
      setD(5'd29, 5'd0, 1, 0, 0, 5'd8, 1, 1);  setE(5'd0, 5'd0);
      step("lw_issue", ev(0, 0, 0, 0, 2'b00, 2'b00, 0, 0));
      setD(5'd8, 5'd1, 1, 1, 0, 5'd9, 1, 0);   setE(5'd29, 5'd0);
      step("loaduse_stall", ev(1, 1, 0, 0, 2'b00, 2'b00, 0, 0));
      setE(5'd0, 5'd0);
      step("loaduse_release", ev(0, 0, 0, 0, 2'b00, 2'b00, 0, 1));
      idleD();  setE(5'd8, 5'd1);
      step("loaduse_fwd_w", ev(0, 0, 0, 0, 2'b01, 2'b00, 0, 1));

      // add $3 in M / in E against beq $3,$4
      setD(5'd1, 5'd2, 1, 1, 0, 5'd3, 1, 0);   setE(5'd0, 5'd0);
      step("add3_issue", ev(0, 0, 0, 0, 2'b00, 2'b00, 0, 1));
      idleD();  setE(5'd1, 5'd2);
      step("add3_in_e", ev(0, 0, 0, 0, 2'b00, 2'b00, 0, 1));
      setD(5'd3, 5'd4, 1, 1, 1, 5'd0, 0, 0);   setE(5'd0, 5'd0);
      step("beq_fwd_m", ev(0, 0, 1, 0, 2'b00, 2'b00, 0, 1));
      setD(5'd1, 5'd2, 1, 1, 0, 5'd3, 1, 0);
      step("add3_again", ev(0, 0, 0, 0, 2'b00, 2'b00, 0, 1));
      setD(5'd3, 5'd4, 1, 1, 1, 5'd0, 0, 0);   setE(5'd1, 5'd2);
      step("beq_stall_e", ev(1, 1, 0, 0, 2'b00, 2'b00, 0, 1));
      setE(5'd0, 5'd0);
      step("beq_release", ev(0, 0, 1, 0, 2'b00, 2'b00, 0, 2));

      // lw $5 in M against jr $5
      setD(5'd29, 5'd0, 1, 0, 0, 5'd5, 1, 1);
      step("lw5_issue", ev(0, 0, 0, 0, 2'b00, 2'b00, 0, 2));
      idleD();  setE(5'd29, 5'd0);
      step("lw5_in_e", ev(0, 0, 0, 0, 2'b00, 2'b00, 0, 2));
      setD(5'd5, 5'd0, 1, 0, 1, 5'd0, 0, 0);   setE(5'd0, 5'd0);
      step("jr_stall_m_load", ev(1, 1, 0, 0, 2'b00, 2'b00, 0, 2));
      step("jr_release", ev(0, 0, 0, 0, 2'b00, 2'b00, 0, 3));

      // writes to $0 are never tracked
      setD(5'd1, 5'd2, 1, 1, 0, 5'd0, 1, 0);
      step("wr_r0_add", ev(0, 0, 0, 0, 2'b00, 2'b00, 0, 3));
      setD(5'd29, 5'd0, 1, 0, 0, 5'd0, 1, 1);
      step("wr_r0_lw", ev(0, 0, 0, 0, 2'b00, 2'b00, 0, 3));
      setD(5'd0, 5'd0, 1, 1, 1, 5'd0, 1, 0);
      step("read_r0", ev(0, 0, 0, 0, 2'b00, 2'b00, 0, 3));
      idleD();  setE(5'd0, 5'd0);
      step("fwd_r0_e", ev(0, 0, 0, 0, 2'b00, 2'b00, 0, 3));

      // ext_stall during a load-use stall holds everything
      setD(5'd29, 5'd0, 1, 0, 0, 5'd8, 1, 1);
      step("lw8_issue2", ev(0, 0, 0, 0, 2'b00, 2'b00, 0, 3));
      setD(5'd8, 5'd1, 1, 1, 0, 5'd9, 1, 0);   setE(5'd29, 5'd0);
      sb.ext_stall = 1'b1;
      for (int i = 0; i < 3; i++) step("ext_hold", ev(1, 0, 0, 0, 2'b00, 2'b00, 0, 3));
      sb.ext_stall = 1'b0;
      step("ext_release_stall", ev(1, 1, 0, 0, 2'b00, 2'b00, 0, 3));
      setE(5'd0, 5'd0);
      step("ext_after", ev(0, 0, 0, 0, 2'b00, 2'b00, 0, 4));
      idleD();  setE(5'd1, 5'd8);
      step("fwd_b_w", ev(0, 0, 0, 0, 2'b00, 2'b01, 0, 4));
      setD(5'd0, 5'd9, 0, 0, 0, 5'd0, 0, 0);   setE(5'd9, 5'd9);
      step("fwd_m_both", ev(0, 0, 0, 1, 2'b10, 2'b10, 0, 4));

      // M has priority over W for the same destination
      setD(5'd1, 5'd2, 1, 1, 0, 5'd6, 1, 0);   setE(5'd0, 5'd0);
      step("add6_a", ev(0, 0, 0, 0, 2'b00, 2'b00, 0, 4));
      step("add6_b", ev(0, 0, 0, 0, 2'b00, 2'b00, 0, 4));
      idleD();  setE(5'd1, 5'd2);
      step("add6_gap", ev(0, 0, 0, 0, 2'b00, 2'b00, 0, 4));
      setE(5'd6, 5'd6);
      step("fwd_m_over_w", ev(0, 0, 0, 0, 2'b10, 2'b10, 0, 4));

      // a load in M is not forwarded to E, only from W
      setD(5'd29, 5'd0, 1, 0, 0, 5'd7, 1, 1);  setE(5'd0, 5'd0);
      step("lw7_issue", ev(0, 0, 0, 0, 2'b00, 2'b00, 0, 4));
      idleD();
      step("lw7_in_e", ev(0, 0, 0, 0, 2'b00, 2'b00, 0, 4));
      setE(5'd7, 5'd7);
      step("no_fwd_m_load", ev(0, 0, 0, 0, 2'b00, 2'b00, 0, 4));
      step("fwd_w_load", ev(0, 0, 0, 0, 2'b01, 2'b01, 0, 4));

      // flush_req alone, and together with a hazard
      setD(5'd1, 5'd2, 1, 1, 0, 5'd7, 1, 0);   setE(5'd0, 5'd0);
      sb.flush_req = 1'b1;
      step("flush_only", ev(0, 1, 0, 0, 2'b00, 2'b00, 0, 4));
      sb.flush_req = 1'b0;
      setD(5'd7, 5'd0, 1, 0, 1, 5'd0, 0, 0);
      step("flushed_not_tracked", ev(0, 0, 0, 0, 2'b00, 2'b00, 0, 4));
      setD(5'd29, 5'd0, 1, 0, 0, 5'd8, 1, 1);
      step("lw8_issue3", ev(0, 0, 0, 0, 2'b00, 2'b00, 0, 4));
      setD(5'd8, 5'd0, 1, 0, 0, 5'd9, 1, 0);
      sb.flush_req = 1'b1;
      step("flush_and_hz", ev(1, 1, 0, 0, 2'b00, 2'b00, 0, 4));
      sb.flush_req = 1'b0;
      idleD();
      step("post_flush_hz", ev(0, 0, 0, 0, 2'b00, 2'b00, 0, 5));

      // div then mfhi from a clean counter
      reset = 1'b1;
      step("reset_again", ev(0, 0, 0, 0, 2'b00, 2'b00, 0, 0));
      reset = 1'b0;
      idleD();  sb.md_start_d = 1'b1;  sb.md_div_d = 1'b1;
      step("div_accept", ev(0, 0, 0, 0, 2'b00, 2'b00, 0, 0));
      idleD();  sb.md_acc_d = 1'b1;
      for (int i = 0; i < 10; i++) step("mfhi_wait_div", ev(1, 1, 0, 0, 2'b00, 2'b00, 1, i));
      step("mfhi_issue_div", ev(0, 0, 0, 0, 2'b00, 2'b00, 0, 10));

      // mult: countdown keeps running through ext_stall, which is not counted
      idleD();  sb.md_start_d = 1'b1;
      step("mult_accept", ev(0, 0, 0, 0, 2'b00, 2'b00, 0, 10));
      idleD();  sb.md_acc_d = 1'b1;  sb.ext_stall = 1'b1;
      for (int i = 0; i < 2; i++) step("mult_ext", ev(1, 0, 0, 0, 2'b00, 2'b00, 1, 10));
      sb.ext_stall = 1'b0;
      for (int i = 0; i < 3; i++) step("mult_wait", ev(1, 1, 0, 0, 2'b00, 2'b00, 1, 10 + i));
      step("mult_issue", ev(0, 0, 0, 0, 2'b00, 2'b00, 0, 13));

      // second mult saturates the 4-bit counter
      idleD();  sb.md_start_d = 1'b1;
      step("mult2_accept", ev(0, 0, 0, 0, 2'b00, 2'b00, 0, 13));
      idleD();  sb.md_acc_d = 1'b1;
      for (int i = 0; i < 5; i++)
         step("mult2_wait_sat", ev(1, 1, 0, 0, 2'b00, 2'b00, 1, (13 + i > 15) ? 15 : 13 + i));
      step("mult2_issue", ev(0, 0, 0, 0, 2'b00, 2'b00, 0, 15));

      // a new div is blocked while busy; async reset mid-countdown clears at once
      idleD();  sb.md_start_d = 1'b1;  sb.md_div_d = 1'b1;
      step("div2_accept", ev(0, 0, 0, 0, 2'b00, 2'b00, 0, 15));
      for (int i = 0; i < 2; i++) step("div_start_blocked", ev(1, 1, 0, 0, 2'b00, 2'b00, 1, 15));
      idleD();  sb.md_acc_d = 1'b1;
      reset = 1'b1;
      step("reset_mid_div", ev(0, 0, 0, 0, 2'b00, 2'b00, 0, 0));
      reset = 1'b0;

      // a flushed div never starts the countdown
      idleD();  sb.md_start_d = 1'b1;  sb.md_div_d = 1'b1;  sb.flush_req = 1'b1;
      step("div_flushed", ev(0, 1, 0, 0, 2'b00, 2'b00, 0, 0));
      sb.flush_req = 1'b0;
      idleD();  sb.md_acc_d = 1'b1;
      step("no_busy_after_flush", ev(0, 0, 0, 0, 2'b00, 2'b00, 0, 0));

      if (exp_q.size() != 0) begin
         bad++;
         $display("FAIL exp_q_drain: got=%0d left required=0", exp_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
